// File: rtl/cursor_pkt_pkg.sv
// Shared cursor packet definitions: sync byte, packet states, checksum.
// Used by both the cursor UART receiver and transmitter.
package cursor_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam int         PKT_LEN   = 5;

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_BTN  = 3'd1;
  localparam logic [2:0] ST_DX   = 3'd2;
  localparam logic [2:0] ST_DY   = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;

  function automatic logic [7:0] pkt_chk(
    input logic [7:0] btn,
    input logic [7:0] dx,
    input logic [7:0] dy
  );
    return btn ^ dx ^ dy;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return v + {15'd0, ~&v};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, start validation, mid-bit sampling.
// Emits a one-cycle byte_valid or byte_err strobe after each stop sample.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    unique case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (s3_q && !s2_q) st_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          vld_d = s2_q;
          err_d = !s2_q;
          st_d  = R_IDLE;
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      s3_q  <= 1'b1;
      st_q  <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q  <= rx;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign byte_data  = sh_q;
  assign byte_valid = vld_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/cursor_uart_rx_decoder.sv
// Cursor link receiver: frames UART bytes into [AA,btn,dx,dy,chk] packets
// and reports good packets plus checksum, framing and gap-timeout errors.
module cursor_uart_rx_decoder
  import cursor_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 13020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        pkt_valid,
  output logic [1:0]  buttons,
  output logic [7:0]  dx,
  output logic [7:0]  dy,
  output logic        chk_err,
  output logic        frame_err,
  output logic        timeout_err,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CLKS - 1);

  logic [7:0] byte_data;
  logic       byte_valid, byte_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  logic [2:0]    pst_q, pst_d;
  logic [7:0]    btn_q, btn_d, dxs_q, dxs_d, dys_q, dys_d;
  logic [1:0]    bo_q, bo_d;
  logic [7:0]    dxo_q, dxo_d, dyo_q, dyo_d;
  logic          pv_q, pv_d, ce_q, ce_d, fe_q, fe_d, te_q, te_d;
  logic [15:0]   good_q, good_d, bad_q, bad_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          expire;

  // A byte strobe in the same cycle as expiry takes precedence.
  assign expire = (pst_q != ST_HUNT) && (tmr_q == TLIM) &&
                  !byte_valid && !byte_err;

  always_comb begin
    pst_d  = pst_q;
    btn_d  = btn_q;
    dxs_d  = dxs_q;
    dys_d  = dys_q;
    bo_d   = bo_q;
    dxo_d  = dxo_q;
    dyo_d  = dyo_q;
    good_d = good_q;
    bad_d  = bad_q;
    pv_d   = 1'b0;
    ce_d   = 1'b0;
    fe_d   = 1'b0;
    te_d   = 1'b0;
    tmr_d  = (pst_q == ST_HUNT) ? '0 : tmr_q + 1'b1;
    unique case (1'b1)
      byte_err: begin
        fe_d  = 1'b1;
        bad_d = sat_inc16(bad_q);
        pst_d = ST_HUNT;
        tmr_d = '0;
      end
      byte_valid: begin
        tmr_d = '0;
        unique case (pst_q)
          ST_HUNT: if (byte_data == SYNC_BYTE) pst_d = ST_BTN;
          ST_BTN: begin
            btn_d = byte_data;
            pst_d = ST_DX;
          end
          ST_DX: begin
            dxs_d = byte_data;
            pst_d = ST_DY;
          end
          ST_DY: begin
            dys_d = byte_data;
            pst_d = ST_CHK;
          end
          ST_CHK: begin
            pst_d = ST_HUNT;
            if (byte_data == pkt_chk(btn_q, dxs_q, dys_q)) begin
              bo_d   = btn_q[1:0];
              dxo_d  = dxs_q;
              dyo_d  = dys_q;
              pv_d   = 1'b1;
              good_d = sat_inc16(good_q);
            end else begin
              ce_d  = 1'b1;
              bad_d = sat_inc16(bad_q);
            end
          end
          default: pst_d = ST_HUNT;
        endcase
      end
      expire: begin
        te_d  = 1'b1;
        bad_d = sat_inc16(bad_q);
        pst_d = ST_HUNT;
        tmr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q  <= ST_HUNT;
      btn_q  <= '0;
      dxs_q  <= '0;
      dys_q  <= '0;
      bo_q   <= '0;
      dxo_q  <= '0;
      dyo_q  <= '0;
      pv_q   <= 1'b0;
      ce_q   <= 1'b0;
      fe_q   <= 1'b0;
      te_q   <= 1'b0;
      good_q <= '0;
      bad_q  <= '0;
      tmr_q  <= '0;
    end else begin
      pst_q  <= pst_d;
      btn_q  <= btn_d;
      dxs_q  <= dxs_d;
      dys_q  <= dys_d;
      bo_q   <= bo_d;
      dxo_q  <= dxo_d;
      dyo_q  <= dyo_d;
      pv_q   <= pv_d;
      ce_q   <= ce_d;
      fe_q   <= fe_d;
      te_q   <= te_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      tmr_q  <= tmr_d;
    end
  end

  assign pkt_valid   = pv_q;
  assign buttons     = bo_q;
  assign dx          = dxo_q;
  assign dy          = dyo_q;
  assign chk_err     = ce_q;
  assign frame_err   = fe_q;
  assign timeout_err = te_q;
  assign good_count  = good_q;
  assign bad_count   = bad_q;

endmodule
